// File: rtl/mac_seq_controller.sv
// Sequential multiply-accumulate controller: shift-and-add of A*B into a wrapping
// accumulator over OP_W cycles, with a sticky overflow flag and a one-cycle done pulse.
module mac_seq_controller #(
    parameter int OP_W  = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  a_in,
    input  logic [OP_W-1:0]  b_in,
    input  logic             acc_clr,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] acc,
    output logic             overflow
);
    localparam int STEP_W = (OP_W > 1) ? $clog2(OP_W) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(OP_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [STEP_W-1:0]  step_q;
    logic [ACC_W-1:0]   a_sh_q;   // multiplicand, pre-shifted by the current step
    logic [OP_W-1:0]    b_sh_q;   // multiplier, bit 0 is the current step's bit
    logic [ACC_W-1:0]   acc_q;
    logic               ovf_q;
    logic               rdy_q;
    logic               busy_q;
    logic               done_q;
    logic [ACC_W:0]     sum_d;

    // One partial product per cycle; the extra top bit is the carry out of the accumulator
    always_comb begin
        sum_d = {1'b0, acc_q} + {1'b0, (b_sh_q[0] ? a_sh_q : {ACC_W{1'b0}})};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (acc_clr) begin
                        acc_q <= '0;
                        ovf_q <= 1'b0;
                    end
                    if (in_valid) begin
                        a_sh_q  <= ACC_W'(a_in);
                        b_sh_q  <= b_in;
                        step_q  <= '0;
                        state_q <= S_RUN;
                        rdy_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    acc_q  <= sum_d[ACC_W-1:0];
                    ovf_q  <= ovf_q | sum_d[ACC_W];
                    a_sh_q <= a_sh_q << 1;
                    b_sh_q <= b_sh_q >> 1;
                    step_q <= step_q + 1'b1;
                    if (step_q == LAST_STEP) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (acc_clr) begin
                        acc_q <= '0;
                        ovf_q <= 1'b0;
                    end
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    rdy_q   <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready = rdy_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign acc      = acc_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_mac_seq_controller.sv
// Self-checking bench for mac_seq_controller: directed scenarios plus randomized ops
// against an arithmetic accumulate model.
module tb_mac_seq_controller;
    localparam int OP_W    = 4;
    localparam int ACC_W   = 8;
    localparam int ACC_MOD = 1 << ACC_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             acc_clr = 1'b0;
    logic [OP_W-1:0]  a_in = '0;
    logic [OP_W-1:0]  b_in = '0;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] acc;
    logic             overflow;

    int errors = 0;
    int checks = 0;
    int unsigned m_acc = 0;
    bit m_ovf = 1'b0;

    mac_seq_controller #(.OP_W(OP_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .acc_clr(acc_clr), .busy(busy),
        .done(done), .acc(acc), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts at a negedge with the DUT idle; ends at the first idle negedge after done.
    task automatic do_op(input int a, input int b, input bit clr, input bit hold, input bit clrmid);
        chk("ready_before_op", in_ready, 1);
        in_valid = 1'b1;
        a_in = OP_W'(a);
        b_in = OP_W'(b);
        acc_clr = clr;
        if (clr) begin
            m_acc = 0;
            m_ovf = 1'b0;
        end
        m_acc = m_acc + a * b;
        if (m_acc >= ACC_MOD) begin
            m_acc = m_acc - ACC_MOD;
            m_ovf = 1'b1;
        end
        @(negedge clk);
        acc_clr = 1'b0;
        if (!hold) in_valid = 1'b0;
        for (int i = 0; i < OP_W; i++) begin
            chk("run_busy", busy, 1);
            chk("run_ready", in_ready, 0);
            chk("run_done", done, 0);
            if (hold) begin
                a_in = OP_W'($urandom_range(15));
                b_in = OP_W'($urandom_range(15));
            end
            acc_clr = clrmid && (i == 1);
            @(negedge clk);
        end
        acc_clr = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_ready", in_ready, 0);
        chk("done_acc", acc, m_acc);
        chk("done_ovf", overflow, m_ovf);
        @(negedge clk);
        chk("post_done", done, 0);
        chk("post_ready", in_ready, 1);
        chk("post_acc_hold", acc, m_acc);
    endtask

    task automatic clear_acc();
        acc_clr = 1'b1;
        m_acc = 0;
        m_ovf = 1'b0;
        @(negedge clk);
        acc_clr = 1'b0;
        chk("clr_acc", acc, 0);
        chk("clr_ovf", overflow, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_acc", acc, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        chk("idle_no_valid", busy, 0);

        do_op(3, 5, 1'b0, 1'b0, 1'b0);
        chk("t1_acc", acc, 15);
        do_op(15, 15, 1'b0, 1'b0, 1'b0);
        chk("t2_acc240", acc, 240);
        do_op(1, 1, 1'b0, 1'b0, 1'b0);
        chk("t2_acc241", acc, 241);
        chk("t2_ovf", overflow, 0);

        clear_acc();
        do_op(15, 15, 1'b0, 1'b0, 1'b0);
        chk("t3_acc225", acc, 225);
        do_op(15, 15, 1'b0, 1'b0, 1'b0);
        chk("t3_acc194", acc, 194);
        chk("t3_ovf", overflow, 1);
        do_op(0, 0, 1'b0, 1'b0, 1'b0);
        chk("t3_sticky", overflow, 1);

        // in_valid held through RUN/DONE with changing operands
        do_op(6, 7, 1'b1, 1'b1, 1'b0);
        chk("t4_acc42", acc, 42);
        do_op(2, 3, 1'b0, 1'b1, 1'b0);
        chk("t4_acc48", acc, 48);
        in_valid = 1'b0;

        clear_acc();
        do_op(10, 10, 1'b0, 1'b0, 1'b0);
        chk("t5_acc100", acc, 100);
        do_op(2, 3, 1'b1, 1'b0, 1'b0);
        chk("t5_clr_accept", acc, 6);
        chk("t5_ovf", overflow, 0);
        do_op(1, 1, 1'b0, 1'b0, 1'b1);
        chk("t5_clr_midrun_ignored", acc, 7);

        // reset on the second RUN step
        in_valid = 1'b1;
        a_in = 4'd7;
        b_in = 4'd9;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_acc = 0;
        m_ovf = 1'b0;
        chk("t6_ready", in_ready, 1);
        chk("t6_busy", busy, 0);
        chk("t6_acc", acc, 0);
        chk("t6_ovf", overflow, 0);
        begin
            int seen_done = 0;
            for (int i = 0; i < 8; i++) begin
                if (done) seen_done++;
                @(negedge clk);
            end
            chk("t6_no_done", seen_done, 0);
        end
        do_op(2, 2, 1'b0, 1'b0, 1'b0);
        chk("t6_acc4", acc, 4);

        for (int n = 0; n < 40; n++) begin
            do_op($urandom_range(15), $urandom_range(15), ($urandom_range(3) == 0),
                  $urandom_range(1) == 1, $urandom_range(1) == 1);
            in_valid = 1'b0;
            if ($urandom_range(3) == 0) clear_acc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
